// File: rtl/dcoc_pkg.sv
// dcoc_pkg: shared types and helpers for the multi-channel DC offset corrector.
//   state_t  : FSM states ACQ (fast acquisition), TRACK (slow tracking), HOLD (frozen)
//   cw_calc  : channel tag width, max(1, $clog2(n))
//   sat_add  : signed add clamped to an aw-bit two's-complement range (aw <= 62)
package dcoc_pkg;

    typedef enum logic [1:0] {ACQ, TRACK, HOLD} state_t;

    function automatic int cw_calc(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int aw);
        logic signed [63:0] s, hi, lo;
        s  = a + b;
        hi = (64'sd1 <<< (aw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return (s > hi) ? hi : (s < lo) ? lo : s;
    endfunction

endpackage

// File: rtl/dcoc_sat_sub.sv
// dcoc_sat_sub: combinational DW+1-bit subtract a-b, reduced to DW bits.
//   a, b : DW-bit signed operands
//   full : exact DW+1-bit difference (feeds the integrators)
//   res  : DW-bit difference; clamped when DCOC_SAT_EN is defined, wrapped otherwise
module dcoc_sat_sub #(
    parameter int DW = 16
) (
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    output logic signed [DW:0]   full,
    output logic signed [DW-1:0] res
);
    assign full = (DW+1)'(a) - (DW+1)'(b);
`ifdef DCOC_SAT_EN
    // Top two bits disagree only when the difference left the DW-bit range.
    assign res = (full[DW] ^ full[DW-1]) ?
                 (full[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}}) :
                 full[DW-1:0];
`else
    assign res = full[DW-1:0];
`endif
endmodule

// File: rtl/dc_offset_correct_mc.sv
// dc_offset_correct_mc: per-channel leaky-integrator DC removal on a tagged,
// time-multiplexed sample stream, fast acquisition then slow tracking.
//   clk, reset (async, active-high)
//   in_valid/in_chan/in_data   : input sample strobe, channel tag, signed sample
//   freeze                     : hold estimates and the acquisition counter
//   restart                    : pulse, re-enter acquisition (estimates kept)
//   out_valid/out_chan/out_data: registered corrected sample, 1 cycle latency
//   dc_rd_chan/dc_rd_level     : combinational estimate readback
//   settled                    : registered, high in TRACK or HOLD-from-TRACK
// Build option: DCOC_SAT_EN clamps the corrected output instead of wrapping.
module dc_offset_correct_mc
    import dcoc_pkg::*;
#(
    parameter int DW      = 16,
    parameter int NCH     = 2,
    parameter int K_FAST  = 6,
    parameter int K_SLOW  = 14,
    parameter int ACQ_LEN = 4096,
    localparam int CW     = cw_calc(NCH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [CW-1:0]        in_chan,
    input  logic signed [DW-1:0] in_data,
    input  logic                 freeze,
    input  logic                 restart,
    output logic                 out_valid,
    output logic [CW-1:0]        out_chan,
    output logic signed [DW-1:0] out_data,
    input  logic [CW-1:0]        dc_rd_chan,
    output logic signed [DW-1:0] dc_rd_level,
    output logic                 settled
);
    localparam int AW = DW + K_SLOW;
    localparam int NW = $clog2(ACQ_LEN + 1);

    state_t               state, state_n;
    logic                 ret_track, ret_track_n;
    logic [NW-1:0]        cnt, cnt_n;
    logic                 settled_n;
    logic signed [AW-1:0] acc [NCH];
    logic signed [AW-1:0] acc_sel, acc_nxt;
    logic                 chan_ok, rd_ok, upd, done;
    logic signed [DW-1:0] dc_in, corr;
    logic signed [DW:0]   corr_full;

    assign chan_ok     = int'(in_chan) < NCH;
    assign rd_ok       = int'(dc_rd_chan) < NCH;
    assign acc_sel     = chan_ok ? acc[in_chan] : '0;
    assign dc_in       = acc_sel[AW-1:K_SLOW];
    assign dc_rd_level = rd_ok ? acc[dc_rd_chan][AW-1:K_SLOW] : '0;
    assign upd         = in_valid && chan_ok && state != HOLD;
    assign done        = in_valid && cnt == NW'(ACQ_LEN - 1);

    dcoc_sat_sub #(.DW(DW)) u_sub (
        .a    (in_data),
        .b    (dc_in),
        .full (corr_full),
        .res  (corr)
    );

    // Scaling the error by 2^(K_SLOW-k) lets both time constants share one
    // accumulator format whose integer part is always bits [AW-1:K_SLOW].
    assign acc_nxt = AW'(sat_add(64'(acc_sel),
                                 (state == ACQ) ? (64'(corr_full) <<< (K_SLOW - K_FAST))
                                                : 64'(corr_full),
                                 AW));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ACQ;
            ret_track <= 1'b0;
            cnt       <= '0;
            settled   <= 1'b0;
        end else begin
            state     <= state_n;
            ret_track <= ret_track_n;
            cnt       <= cnt_n;
            settled   <= settled_n;
        end
    end

    always_comb begin
        state_n     = state;
        ret_track_n = ret_track;
        cnt_n       = cnt;
        if (restart) begin
            state_n     = ACQ;
            ret_track_n = 1'b0;
            cnt_n       = '0;
        end else begin
            case (state)
                ACQ: begin
                    cnt_n = in_valid ? cnt + 1'b1 : cnt;
                    // A freeze landing on the final acquisition beat must
                    // return to TRACK, or the counter would overrun the limit.
                    if (freeze) begin
                        state_n     = HOLD;
                        ret_track_n = done;
                    end else if (done) begin
                        state_n = TRACK;
                    end
                end
                TRACK: begin
                    if (freeze) begin
                        state_n     = HOLD;
                        ret_track_n = 1'b1;
                    end
                end
                default: begin
                    if (!freeze) state_n = ret_track ? TRACK : ACQ;
                end
            endcase
        end
    end

    always_comb begin
        settled_n = (state_n == TRACK) || (state_n == HOLD && ret_track_n);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) acc[i] <= '0;
            out_valid <= 1'b0;
            out_chan  <= '0;
            out_data  <= '0;
        end else begin
            if (upd) acc[in_chan] <= acc_nxt;
            out_valid <= in_valid;
            if (in_valid) begin
                out_chan <= in_chan;
                out_data <= corr;
            end
        end
    end
endmodule

// File: tb/tb_dc_offset_correct_mc.sv
// tb_dc_offset_correct_mc: directed table plus multi-cycle sequences for dc_offset_correct_mc.
module tb_dc_offset_correct_mc;
    localparam int DW = 16;
    localparam int NCH = 3;
    localparam int CW = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic [CW-1:0]        in_chan;
    logic signed [DW-1:0] in_data;
    logic                 freeze;
    logic                 restart;
    logic                 out_valid;
    logic [CW-1:0]        out_chan;
    logic signed [DW-1:0] out_data;
    logic [CW-1:0]        dc_rd_chan;
    logic signed [DW-1:0] dc_rd_level;
    logic                 settled;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dc_offset_correct_mc #(.DW(DW), .NCH(NCH), .K_FAST(6), .K_SLOW(14), .ACQ_LEN(4096)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_chan     (in_chan),
        .in_data     (in_data),
        .freeze      (freeze),
        .restart     (restart),
        .out_valid   (out_valid),
        .out_chan    (out_chan),
        .out_data    (out_data),
        .dc_rd_chan  (dc_rd_chan),
        .dc_rd_level (dc_rd_level),
        .settled     (settled)
    );

    typedef struct {
        logic          v;
        logic [CW-1:0] c;
        int            d;
        logic [CW-1:0] rd;
        int            eo;
        int            edc;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s actual=%0d expected=[%0d,%0d]", name, act, lo, hi);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [CW-1:0] c, input int d);
        in_valid = 1'b1;
        in_chan  = c;
        in_data  = DW'(d);
        tick();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        tbl[0] = '{1'b1, 2'd0, 1000,   2'd0, 1000,   15};
        tbl[1] = '{1'b1, 2'd1, -500,   2'd1, -500,   -8};
        tbl[2] = '{1'b0, 2'd0, 0,      2'd0, 0,      15};
        tbl[3] = '{1'b1, 2'd0, 1000,   2'd0, 985,    31};
        tbl[4] = '{1'b1, 2'd1, -500,   2'd1, -492,   -16};
        tbl[5] = '{1'b1, 2'd3, 123,    2'd0, 123,    31};
        tbl[6] = '{1'b1, 2'd2, -32768, 2'd2, -32768, -512};
`ifdef DCOC_SAT_EN
        tbl[7] = '{1'b1, 2'd2, 32767,  2'd2, 32767,  7};
`else
        tbl[7] = '{1'b1, 2'd2, 32767,  2'd2, -32257, 7};
`endif

        reset = 1'b1; in_valid = 1'b0; in_chan = '0; in_data = '0;
        freeze = 1'b0; restart = 1'b0; dc_rd_chan = '0;
        #12;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_chan", int'(out_chan), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_settled", int'(settled), 0);
        chk("rst_dc", int'(dc_rd_level), 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            dc_rd_chan = tbl[i].rd;
            in_valid   = tbl[i].v;
            in_chan    = tbl[i].c;
            in_data    = DW'(tbl[i].d);
            tick();
            chk($sformatf("tbl%0d_valid", i), int'(out_valid), int'(tbl[i].v));
            if (tbl[i].v) begin
                chk($sformatf("tbl%0d_chan", i), int'(out_chan), int'(tbl[i].c));
                chk($sformatf("tbl%0d_data", i), int'(out_data), tbl[i].eo);
            end
            chk($sformatf("tbl%0d_dc", i), int'(dc_rd_level), tbl[i].edc);
        end

        // Acquisition to TRACK on the 4096th beat
        restart = 1'b1; idle(); restart = 1'b0;
        chk("acq_settled0", int'(settled), 0);
        for (int i = 0; i < 4096; i++) begin
            beat(CW'(i % 2), (i % 2) ? -500 : 1000);
            if (i == 4094) chk("acq_settled_pre", int'(settled), 0);
        end
        chk("acq_settled", int'(settled), 1);
        chk_rng("acq_out_ch1", int'(out_data), -1, 1);
        dc_rd_chan = 2'd0; #1;
        chk("acq_dc0", int'(dc_rd_level), 1000);
        dc_rd_chan = 2'd1; #1;
        chk("acq_dc1", int'(dc_rd_level), -500);

        // Freeze in TRACK: estimates held, correction still applied
        dc_rd_chan = 2'd0;
        freeze = 1'b1; idle();
        for (int i = 0; i < 100; i++) begin
            beat(2'd0, 1500);
            chk("frz_out_ch0", int'(out_data), 500);
            beat(2'd1, 0);
            chk("frz_out_ch1", int'(out_data), 500);
        end
        chk("frz_dc0", int'(dc_rd_level), 1000);
        chk("frz_settled", int'(settled), 1);
        freeze = 1'b0; idle();
        chk("unfrz_settled", int'(settled), 1);

        // restart wins over freeze; next sample uses the fast constant
        restart = 1'b1; freeze = 1'b1; idle();
        restart = 1'b0; freeze = 1'b0;
        chk("rsfz_settled", int'(settled), 0);
        beat(2'd0, 1064);
        chk("rsfz_out", int'(out_data), 64);
        chk("rsfz_dc0", int'(dc_rd_level), 1001);

        // Freeze during ACQ delays settling by the frozen beat count
        restart = 1'b1; idle(); restart = 1'b0;
        for (int i = 0; i < 4296; i++) begin
            freeze = (i >= 100 && i < 300);
            beat(CW'(i % 2), (i % 2) ? -500 : 1001);
            if (i == 200) chk("acqfrz_hold_settled", int'(settled), 0);
            if (i == 4294) chk("acqfrz_settled_pre", int'(settled), 0);
        end
        freeze = 1'b0;
        chk("acqfrz_settled", int'(settled), 1);

        // Step in TRACK moves the estimate slowly
        dc_rd_chan = 2'd0;
        for (int i = 0; i < 128; i++) beat(CW'(i % 2), (i % 2) ? -500 : 1200);
        chk_rng("step_dc0", int'(dc_rd_level), 1001, 1003);
        dc_rd_chan = 2'd1; #1;
        chk("step_dc1", int'(dc_rd_level), -500);

        // Corrected sample overflow: DC -1000, input full scale
        restart = 1'b1; idle(); restart = 1'b0;
        for (int i = 0; i < 4096; i++) beat(CW'(i % 2), (i % 2) ? -500 : -1000);
        dc_rd_chan = 2'd0; #1;
        chk("ovf_dc0", int'(dc_rd_level), -1000);
        beat(2'd0, 32767);
`ifdef DCOC_SAT_EN
        chk("ovf_out", int'(out_data), 32767);
`else
        chk("ovf_out", int'(out_data), -31769);
`endif

        // Asynchronous reset between clock edges
        in_valid = 1'b1; in_chan = 2'd0; in_data = 16'sd777;
        #2 reset = 1'b1;
        #1;
        chk("areset_valid", int'(out_valid), 0);
        chk("areset_dc", int'(dc_rd_level), 0);
        chk("areset_settled", int'(settled), 0);
        reset = 1'b0;
        tick();
        chk("post_rst_valid", int'(out_valid), 1);
        chk("post_rst_data", int'(out_data), 777);
        chk("post_rst_chan", int'(out_chan), 0);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dc_offset_correct_mc.md
Name: dc_offset_correct_mc

Overview:
Multi-channel, parametrised DC offset corrector for the receiver DDC front end, placed between ADC capture and the mixers.
- Takes a channel-tagged, time-multiplexed sample stream (e.g. I/Q or multiple ADCs) and keeps one leaky-integrator DC estimate per channel.
- Uses a fast time constant during acquisition, then a slow one for tracking. Tracking can be frozen or restarted.
- Emits corrected samples with a registered valid/channel tag.

Parameters:
DW, 16, sample width (signed)
NCH, 2, number of interleaved channels (>=1)
K_FAST, 6, integrator shift during ACQ (time constant 2^K_FAST samples per channel)
K_SLOW, 14, integrator shift during TRACK; must be > K_FAST
ACQ_LEN, 4096, valid input beats (all channels) spent in ACQ

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
in_valid  in  1  sample strobe
in_chan  in  CW=max(1,$clog2(NCH))  channel tag of in_data
in_data  in  DW  signed sample
freeze  in  1  hold all estimates and the ACQ counter
restart  in  1  single-cycle pulse: re-enter ACQ
out_valid  out  1  corrected sample strobe
out_chan  out  CW  tag of out_data
out_data  out  DW  signed corrected sample
dc_rd_chan  in  CW  readback channel select
dc_rd_level  out  DW  DC estimate of dc_rd_chan (combinational from the register array)
settled  out  1  high in TRACK or HOLD

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high. On reset, all accumulators, counter and outputs clear: out_valid=0, out_chan=0, out_data=0, settled=0, state=ACQ. Deasserting reset mid-stream restarts acquisition from a zero estimate.
- Accumulator per channel: acc[c], signed, AW=DW+K_SLOW bits. dc[c]=acc[c][AW-1:K_SLOW].
- Correction on in_valid: corr = in_data - dc[in_chan], computed at DW+1 bits, then reduced to DW (see optional feature).
- Accumulator update on in_valid && state!=HOLD: acc[in_chan] += sext(corr) << (K_SLOW-k), where k=K_FAST in ACQ and k=K_SLOW in TRACK.
  - The sum saturates to the signed AW range and never wraps.
  - Only acc[in_chan] changes.
- Latency: out_data/out_chan/out_valid are registered exactly 1 cycle after the in_valid cycle. Throughput is 1 sample/cycle. There is no backpressure.
- in_chan >= NCH: the sample passes uncorrected (dc taken as 0), no accumulator update, out_chan = in_chan.
- FSM:
  - ACQ: counter increments per in_valid beat. At count==ACQ_LEN-1 with in_valid -> TRACK. freeze -> HOLD (counter kept).
  - TRACK: freeze -> HOLD.
  - HOLD: estimates constant, correction still applied. freeze low -> previous state (ACQ or TRACK, tracked by a 1-bit return flag).
  - restart in any state -> ACQ with counter=0; accumulators retained. restart has priority over freeze in the same cycle.
- settled is registered: 1 in TRACK, or in HOLD when the return state is TRACK.
- Mode switches take effect for the sample accepted in the cycle after the transition.

Optional Feature:
DCOC_SAT_EN
- Defined: corr saturates to [-2^(DW-1), 2^(DW-1)-1].
- Undefined: corr truncates to the low DW bits (wraps), which matches the legacy single-channel behaviour.
- The accumulator always uses the unsaturated DW+1-bit corr.

Decomposition:
- Package dcoc_pkg: state enum {ACQ, TRACK, HOLD}; CW calculation function; sat_add helper function.
- Natural sub-module: dcoc_sat_sub. It is a combinational DW+1-bit subtract with optional clamp, used for corr. The accumulator array and FSM stay in the top.

Test Plan:
1. NCH=2, ch0 const 1000, ch1 const -500, interleaved every cycle -> settled rises after 4096 beats; dc_rd_level within ±1 of 1000 / -500; out_data within ±1 of 0.
2. After settling, step ch0 to 1200 -> dc[ch0] moves <3 LSB in the first 64 ch0 samples (slow constant); ch1 estimate unchanged.
3. freeze high for 1000 beats while the input steps -> dc_rd_level constant and out_data = in - held dc. Release -> returns to prior state. Freeze during ACQ holds the counter, so settled is delayed by the frozen beat count.
4. restart and freeze asserted together in TRACK -> next state ACQ, settled=0, counter=0.
5. ch0 dc settled at -1000, then input 32767 -> DCOC_SAT_EN: out_data=32767. Without the macro: out_data=-31769.
6. Assert reset asynchronously mid-burst (between clock edges) -> out_valid=0 and dc_rd_level=0 immediately. After release, the first output equals the input, one cycle later.
